// File: rtl/star_pkg.sv
// Shared types and constants for the star-finding scan controller and its
// raster counter.
package star_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_CHECK    = 3'd2,
        ST_STG_GO   = 3'd3,
        ST_STG_WAIT = 3'd4,
        ST_STEP     = 3'd5,
        ST_DONE     = 3'd6
    } scan_state_e;

    localparam int DEF_IMG_W = 160;
    localparam int DEF_IMG_H = 120;
    localparam int DEF_N_STG = 5;

    // Stage slots in the per-star sequence.
    localparam int STG_ROWS  = 0;
    localparam int STG_L     = 1;
    localparam int STG_R     = 2;
    localparam int STG_DRAW  = 3;
    localparam int STG_CLEAN = 4;

    // Width of an index over n items, never zero bits wide.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Raster position counter: x/y coordinates and the linear RAM address, with
// an incremental address so no multiplier is needed.
module scan_counter
    import star_pkg::*;
#(
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter int XSZ     = 8,
    parameter int YSZ     = 7,
    parameter int ADDR_SZ = 15
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clr_i,
    input  logic               step_i,
    output logic [XSZ-1:0]     x_o,
    output logic [YSZ-1:0]     y_o,
    output logic [ADDR_SZ-1:0] addr_o,
    output logic               last_pixel_o
);

    localparam logic [XSZ-1:0] X_LAST = XSZ'(IMG_W - 1);
    localparam logic [YSZ-1:0] Y_LAST = YSZ'(IMG_H - 1);

    logic [XSZ-1:0]     x_q, x_d;
    logic [YSZ-1:0]     y_q, y_d;
    logic [ADDR_SZ-1:0] addr_q, addr_d;

    // Next raster position: clear wins over step; x wraps into the next row.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clr_i) begin
            x_d    = {XSZ{1'b0}};
            y_d    = {YSZ{1'b0}};
            addr_d = {ADDR_SZ{1'b0}};
        end else if (step_i) begin
            addr_d = addr_q + ADDR_SZ'(1);
            if (x_q == X_LAST) begin
                x_d = {XSZ{1'b0}};
                y_d = y_q + YSZ'(1);
            end else begin
                x_d = x_q + XSZ'(1);
                y_d = y_q;
            end
        end else begin
            addr_d = addr_q;
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q    <= {XSZ{1'b0}};
            y_q    <= {YSZ{1'b0}};
            addr_q <= {ADDR_SZ{1'b0}};
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign x_o          = x_q;
    assign y_o          = y_q;
    assign addr_o       = addr_q;
    assign last_pixel_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/star_scan_ctrl.sv
// Top-level scan controller: raster-scans the image RAM, thresholds each pixel
// and runs the enabled per-star stages through go/done handshakes.
module star_scan_ctrl
    import star_pkg::*;
#(
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H,
    parameter int XSZ       = 8,
    parameter int YSZ       = 7,
    parameter int ADDR_SZ   = 15,
    parameter int COL_SZ    = 3,
    parameter int THRESHOLD = 0,
    parameter int RD_LAT    = 1,
    parameter int N_STG     = DEF_N_STG,
    parameter int CNT_SZ    = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic [N_STG-1:0]   stage_en,
    input  logic [COL_SZ-1:0]  pix_q,
    output logic [ADDR_SZ-1:0] rd_addr,
    output logic [XSZ-1:0]     x,
    output logic [YSZ-1:0]     y,
    output logic [N_STG-1:0]   stage_go,
    input  logic [N_STG-1:0]   stage_done,
    output logic               busy,
    output logic               done,
    output logic [CNT_SZ-1:0]  star_count,
    output logic               overflow
);

    localparam int IDX_SZ = idx_width(N_STG);
    localparam int LAT_SZ = idx_width(RD_LAT);

    localparam logic [IDX_SZ-1:0] IDX_LAST = IDX_SZ'(N_STG - 1);
    localparam logic [LAT_SZ-1:0] LAT_LAST = LAT_SZ'(RD_LAT - 1);
    localparam logic [COL_SZ-1:0] THR      = COL_SZ'(THRESHOLD);
    localparam logic [CNT_SZ-1:0] CNT_MAX  = {CNT_SZ{1'b1}};

    scan_state_e        state_q, state_d;
    logic [LAT_SZ-1:0]  lat_q, lat_d;
    logic [IDX_SZ-1:0]  idx_q, idx_d;
    logic [N_STG-1:0]   en_q, en_d;
    logic [CNT_SZ-1:0]  cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, done_q;
    logic               clr_s, step_s, abort_s, last_pixel_s;
    logic [N_STG-1:0]   go_s;

    scan_counter #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .XSZ     (XSZ),
        .YSZ     (YSZ),
        .ADDR_SZ (ADDR_SZ)
    ) u_scan_counter (
        .clk          (clk),
        .resetn       (resetn),
        .clr_i        (clr_s),
        .step_i       (step_s),
        .x_o          (x),
        .y_o          (y),
        .addr_o       (rd_addr),
        .last_pixel_o (last_pixel_s)
    );

    assign abort_s = abort && (state_q != ST_IDLE);

    // Next-state, stage sequencing and star counting; abort overrides all.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        idx_d   = idx_q;
        en_d    = en_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        clr_s   = 1'b0;
        step_s  = 1'b0;
        go_s    = {N_STG{1'b0}};
        if (abort_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        clr_s   = 1'b1;
                        cnt_d   = {CNT_SZ{1'b0}};
                        ovf_d   = 1'b0;
                        en_d    = stage_en;
                        lat_d   = {LAT_SZ{1'b0}};
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (lat_q == LAT_LAST) begin
                        lat_d   = {LAT_SZ{1'b0}};
                        state_d = ST_CHECK;
                    end else begin
                        lat_d   = lat_q + LAT_SZ'(1);
                    end
                end
                ST_CHECK: begin
                    if (pix_q > THR) begin
                        // A saturated counter holds and flags the lost star.
                        if (cnt_q == CNT_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_SZ'(1);
                        end
                        idx_d   = {IDX_SZ{1'b0}};
                        state_d = ST_STG_GO;
                    end else begin
                        state_d = ST_STEP;
                    end
                end
                ST_STG_GO: begin
                    if (en_q[idx_q]) begin
                        go_s[idx_q] = 1'b1;
                        state_d     = ST_STG_WAIT;
                    end else if (idx_q == IDX_LAST) begin
                        state_d = ST_STEP;
                    end else begin
                        idx_d   = idx_q + IDX_SZ'(1);
                    end
                end
                ST_STG_WAIT: begin
                    if (stage_done[idx_q]) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_STEP;
                        end else begin
                            idx_d   = idx_q + IDX_SZ'(1);
                            state_d = ST_STG_GO;
                        end
                    end else begin
                        state_d = ST_STG_WAIT;
                    end
                end
                ST_STEP: begin
                    step_s  = 1'b1;
                    lat_d   = {LAT_SZ{1'b0}};
                    state_d = last_pixel_s ? ST_DONE : ST_READ;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Controller state and result registers; busy/done follow the next state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            lat_q   <= {LAT_SZ{1'b0}};
            idx_q   <= {IDX_SZ{1'b0}};
            en_q    <= {N_STG{1'b0}};
            cnt_q   <= {CNT_SZ{1'b0}};
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // stage_go is decoded from the state register but gated by abort in the
    // same cycle, so an aborted STG_GO never launches a sub-engine.
    assign stage_go   = go_s;
    assign busy       = busy_q;
    assign done       = done_q;
    assign star_count = cnt_q;
    assign overflow   = ovf_q;

endmodule
